way_miss_controller: RTL
========================

WAY_MISS_CONTROLLER -- requirements
Module: way_miss_controller

Interface
REQ-001 The module SHALL have parameters: COUNTER_WIDTH, default 8, age width; NUM_WAYS, default 4, ways per set; DATA_WIDTH, default 32, word width; BLOCK_SIZE, default 32, block bytes; ADDRESS_WIDTH, default 32, address width.
REQ-002 The module SHALL derive OFFSET_WIDTH = $clog2(BLOCK_SIZE) and TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The module SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  request hit
- resp_rdata  out  DATA_WIDTH  read/returned data
- way_tag  in  NUM_WAYS*TAG_WIDTH  per-way tags, way i at slice i
- way_valid, way_dirty, way_expired  in  NUM_WAYS each  per-way state
- way_age  in  NUM_WAYS*COUNTER_WIDTH  per-way age
- way_data  in  NUM_WAYS*DATA_WIDTH  per-way dataOut
- way_accessed  out  NUM_WAYS  one-hot access pulse
- accessed_way_age  out  COUNTER_WIDTH  age of accessed way
- way_allocate  out  NUM_WAYS  one-hot allocate pulse
- way_wen  out  NUM_WAYS  one-hot write enable
- way_din  out  DATA_WIDTH  data to ways
- way_address  out  ADDRESS_WIDTH  address to ways
- mem_req_valid  out  1  memory request
- mem_req_write  out  1  1 = writeback, 0 = fill read
- mem_addr  out  ADDRESS_WIDTH  block address, offset bits zero
- mem_wdata  out  DATA_WIDTH  writeback data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  DATA_WIDTH  fill data

Function
REQ-005 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, ALLOCATE, RESPOND.
REQ-006 req_ready SHALL be 1 only in IDLE; req_valid&&req_ready SHALL register req_write/addr/wdata and move to LOOKUP.
REQ-007 In LOOKUP, hit SHALL mean way_valid[i] and way_tag slice i == registered addr[ADDRESS_WIDTH-1:OFFSET_WIDTH]; multiple matches resolve to the lowest index.
REQ-008 Hit SHALL go LOOKUP->RESPOND; in RESPOND: way_accessed[hit]=1, accessed_way_age=way_age[hit], resp_valid=1, resp_hit=1, resp_rdata=way_data[hit] (read) or req_wdata (write).
REQ-009 On a write hit, RESPOND SHALL also assert way_wen[hit]=1, way_din=req_wdata, way_address=req_addr.
REQ-010 On miss, the victim SHALL be captured in LOOKUP: lowest-index invalid way, else lowest-index expired way, else the largest way_age (lowest index on tie).
REQ-011 Miss with a valid dirty victim SHALL go to WRITEBACK, otherwise to FILL_REQ.
REQ-012 WRITEBACK SHALL hold mem_req_valid=1, mem_req_write=1, mem_addr={victim tag, zero offset}, mem_wdata=victim data until mem_ready, then go to FILL_REQ.
REQ-013 FILL_REQ SHALL hold mem_req_valid=1, mem_req_write=0, mem_addr={req tag, zero offset} until mem_ready, then go to FILL_WAIT; mem_rvalid with mem_ready in the same cycle SHALL capture mem_rdata and go directly to ALLOCATE.
REQ-014 FILL_WAIT SHALL capture mem_rdata on mem_rvalid and go to ALLOCATE; mem_rvalid in any other state SHALL be ignored.
REQ-015 ALLOCATE (one cycle) SHALL pulse way_allocate, way_wen and way_accessed at the victim, with accessed_way_age=victim age, way_address=req_addr, way_din=req_wdata (write) or fill data (read), then go to RESPOND.
REQ-016 RESPOND after a miss SHALL give resp_valid=1, resp_hit=0, resp_rdata=way_din value; RESPOND SHALL always return to IDLE.
REQ-017 Hit latency SHALL be 2 cycles from acceptance to resp_valid; a clean miss with zero-wait memory SHALL take 4 cycles.
REQ-018 All one-hot outputs, resp_valid and mem_req_valid SHALL be 0 outside the states named above.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, with every output 0 except req_ready=1 and all registered request/victim/fill data cleared; an outstanding memory transaction SHALL be abandoned.

Verification
REQ-020 Read hit: way2 valid, tag 0x0000ABC, age 5; read 0x00015780 -> resp_valid at cycle+2, resp_hit=1, way_accessed=4'b0100, accessed_way_age=5.
REQ-021 Clean read miss: way1 invalid, mem_ready=1, mem_rvalid next cycle with 0xDEADBEEF -> way_allocate=4'b0010, way_din=0xDEADBEEF, resp_hit=0, resp_rdata=0xDEADBEEF.
REQ-022 Dirty victim: all valid, way3 age 0xFF dirty -> WRITEBACK with mem_addr={way3 tag,5'b0}, mem_wdata=way3 data, held 3 cycles while mem_ready=0, then fill.
REQ-023 Write miss with way0 expired and others valid -> victim way0, way_din=req_wdata, way_wen=4'b0001.
REQ-024 rst_n deasserted in FILL_WAIT -> outputs cleared asynchronously, req_ready=1 after release, late mem_rvalid ignored.

Source files
------------

// File: rtl/way_miss_controller.sv
// Single-outstanding-request cache way controller: picks a hit way or a replacement
// victim, runs writeback and fill against memory, then allocates and responds.
module way_miss_controller #(
    parameter int COUNTER_WIDTH = 8,
    parameter int NUM_WAYS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    output logic                              resp_valid,
    output logic                              resp_hit,
    output logic [DATA_WIDTH-1:0]             resp_rdata,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]     way_tag,
    input  logic [NUM_WAYS-1:0]               way_valid,
    input  logic [NUM_WAYS-1:0]               way_dirty,
    input  logic [NUM_WAYS-1:0]               way_expired,
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0]    way_data,
    output logic [NUM_WAYS-1:0]               way_accessed,
    output logic [COUNTER_WIDTH-1:0]          accessed_way_age,
    output logic [NUM_WAYS-1:0]               way_allocate,
    output logic [NUM_WAYS-1:0]               way_wen,
    output logic [DATA_WIDTH-1:0]             way_din,
    output logic [ADDRESS_WIDTH-1:0]          way_address,
    output logic                              mem_req_valid,
    output logic                              mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_ready,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);

    // state     | meaning
    // IDLE      | ready for a new request
    // LOOKUP    | compare tags, capture hit way or victim
    // WRITEBACK | write dirty victim block to memory
    // FILL_REQ  | request the missing block
    // FILL_WAIT | wait for fill data
    // ALLOCATE  | install the block into the victim way
    // RESPOND   | one-cycle response strobe
    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, ALLOCATE, RESPOND
    } state_t;

    localparam int IDX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    state_t state_q, state_d;

    logic                     req_write_q;
    logic [ADDRESS_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0]    req_wdata_q;
    logic                     hit_q;
    logic [IDX_WIDTH-1:0]     hit_idx_q;
    logic [IDX_WIDTH-1:0]     vic_idx_q;
    logic [TAG_WIDTH-1:0]     vic_tag_q;
    logic [DATA_WIDTH-1:0]    vic_data_q;
    logic [COUNTER_WIDTH-1:0] vic_age_q;
    logic [DATA_WIDTH-1:0]    fill_q;

    logic [TAG_WIDTH-1:0]     tag_arr  [NUM_WAYS];
    logic [COUNTER_WIDTH-1:0] age_arr  [NUM_WAYS];
    logic [DATA_WIDTH-1:0]    data_arr [NUM_WAYS];

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_unpack
        assign tag_arr[g]  = way_tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign age_arr[g]  = way_age[g*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign data_arr[g] = way_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [TAG_WIDTH-1:0] req_tag;
    assign req_tag = req_addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH];

    logic                 hit_any, inv_any, exp_any;
    logic [IDX_WIDTH-1:0] hit_idx, inv_idx, exp_idx, age_idx, vic_idx;

    // Descending scans leave the lowest matching index in each *_idx.
    always_comb begin
        hit_any = 1'b0;
        inv_any = 1'b0;
        exp_any = 1'b0;
        hit_idx = '0;
        inv_idx = '0;
        exp_idx = '0;
        age_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_valid[i] && (tag_arr[i] == req_tag)) begin
                hit_any = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
            if (!way_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_WIDTH'(i);
            end
            if (way_expired[i]) begin
                exp_any = 1'b1;
                exp_idx = IDX_WIDTH'(i);
            end
        end
        for (int i = 1; i < NUM_WAYS; i++) begin
            if (age_arr[i] > age_arr[age_idx]) age_idx = IDX_WIDTH'(i);
        end
        vic_idx = inv_any ? inv_idx : (exp_any ? exp_idx : age_idx);
    end

    logic fill_capture;
    assign fill_capture = ((state_q == FILL_REQ) && mem_ready && mem_rvalid) ||
                          ((state_q == FILL_WAIT) && mem_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            vic_idx_q   <= '0;
            vic_tag_q   <= '0;
            vic_data_q  <= '0;
            vic_age_q   <= '0;
            fill_q      <= '0;
        end else begin
            if ((state_q == IDLE) && req_valid) begin
                req_write_q <= req_write;
                req_addr_q  <= req_addr;
                req_wdata_q <= req_wdata;
            end
            if (state_q == LOOKUP) begin
                hit_q      <= hit_any;
                hit_idx_q  <= hit_idx;
                vic_idx_q  <= vic_idx;
                vic_tag_q  <= tag_arr[vic_idx];
                vic_data_q <= data_arr[vic_idx];
                vic_age_q  <= age_arr[vic_idx];
            end
            if (fill_capture) fill_q <= mem_rdata;
        end
    end

    logic [NUM_WAYS-1:0]   hit_oh, vic_oh;
    logic [DATA_WIDTH-1:0] alloc_data;
    assign hit_oh     = NUM_WAYS'(1) << hit_idx_q;
    assign vic_oh     = NUM_WAYS'(1) << vic_idx_q;
    assign alloc_data = req_write_q ? req_wdata_q : fill_q;

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_hit         = 1'b0;
        resp_rdata       = '0;
        way_accessed     = '0;
        accessed_way_age = '0;
        way_allocate     = '0;
        way_wen          = '0;
        way_din          = '0;
        way_address      = '0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit_any)                                     state_d = RESPOND;
                else if (way_valid[vic_idx] && way_dirty[vic_idx]) state_d = WRITEBACK;
                else                                             state_d = FILL_REQ;
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_addr      = {vic_tag_q, {OFFSET_WIDTH{1'b0}}};
                mem_wdata     = vic_data_q;
                if (mem_ready) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {req_tag, {OFFSET_WIDTH{1'b0}}};
                if (mem_ready) state_d = mem_rvalid ? ALLOCATE : FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rvalid) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                way_allocate     = vic_oh;
                way_wen          = vic_oh;
                way_accessed     = vic_oh;
                accessed_way_age = vic_age_q;
                way_address      = req_addr_q;
                way_din          = alloc_data;
                state_d          = RESPOND;
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                if (hit_q) begin
                    way_accessed     = hit_oh;
                    accessed_way_age = age_arr[hit_idx_q];
                    resp_rdata       = req_write_q ? req_wdata_q : data_arr[hit_idx_q];
                    if (req_write_q) begin
                        way_wen     = hit_oh;
                        way_din     = req_wdata_q;
                        way_address = req_addr_q;
                    end
                end else begin
                    resp_rdata = alloc_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
